// File: rtl/fetch_decode_latch.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_latch
//  Description : IF/ID pipeline register with a one-entry skid buffer.
//                Captures each fetched word and its PC+4, holds it across
//                decode stalls, squashes it on flush, and parks a word that
//                arrives during a stall so that fetch does not have to
//                refetch it. A valid HALT reaching decode freezes the latch
//                until reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_latch #(
    parameter int          WORD_W      = 32,
    parameter logic [31:0] NOP_INSTR   = 32'h0,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic [WORD_W-1:0] npc_i,
    input  logic              stall,
    input  logic              flush,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] npc_o,
    output logic              valid_o,
    output logic              fetch_stall,
    output logic              halt_o
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SKID   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] c_bubble_instr = NOP_INSTR[WORD_W-1:0];
    localparam logic [WORD_W-1:0] c_zero_word    = '0;

    state_t              state_q,      state_d;
    logic [WORD_W-1:0]   instr_q,      instr_d;
    logic [WORD_W-1:0]   npc_q,        npc_d;
    logic                valid_q,      valid_d;
    logic [WORD_W-1:0]   skid_instr_q, skid_instr_d;
    logic [WORD_W-1:0]   skid_npc_q,   skid_npc_d;
    logic                halt_q,       halt_d;

    logic                w_fetch_stall;
    logic                w_accept;
    logic                w_main_is_halt;

    // Fetch handshake and HALT detection on the word currently in decode.
    always_comb begin
        w_fetch_stall  = (state_q == ST_SKID) || (state_q == ST_HALTED);
        w_accept       = ihit && !w_fetch_stall && !flush;
        w_main_is_halt = valid_q && (instr_q[WORD_W-1 -: 6] == HALT_OPCODE);
    end

    // Next-state logic: flush beats halt detection, which beats stall/normal flow.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        npc_d        = npc_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        halt_d       = halt_q;

        case (state_q)
            ST_HALTED: begin
                // Frozen until reset; flush and fetch are ignored.
            end
            default: begin
                if (flush) begin
                    instr_d      = c_bubble_instr;
                    npc_d        = c_zero_word;
                    valid_d      = 1'b0;
                    skid_instr_d = c_zero_word;
                    skid_npc_d   = c_zero_word;
                    state_d      = ST_RUN;
                end else if (w_main_is_halt) begin
                    // HALT is in decode: keep it there, drop anything younger.
                    halt_d       = 1'b1;
                    skid_instr_d = c_zero_word;
                    skid_npc_d   = c_zero_word;
                    state_d      = ST_HALTED;
                end else if (state_q == ST_SKID) begin
                    if (!stall) begin
                        instr_d      = skid_instr_q;
                        npc_d        = skid_npc_q;
                        valid_d      = 1'b1;
                        skid_instr_d = c_zero_word;
                        skid_npc_d   = c_zero_word;
                        state_d      = ST_RUN;
                    end
                end else if (stall) begin
                    // Decode holds its word; park an arriving word in the skid.
                    if (w_accept) begin
                        skid_instr_d = imemload;
                        skid_npc_d   = npc_i;
                        state_d      = ST_SKID;
                    end
                end else if (w_accept) begin
                    instr_d = imemload;
                    npc_d   = npc_i;
                    valid_d = 1'b1;
                end else begin
                    instr_d = c_bubble_instr;
                    npc_d   = c_zero_word;
                    valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ST_RUN;
            instr_q      <= c_bubble_instr;
            npc_q        <= c_zero_word;
            valid_q      <= 1'b0;
            skid_instr_q <= c_zero_word;
            skid_npc_q   <= c_zero_word;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            npc_q        <= npc_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
            halt_q       <= halt_d;
        end
    end

    assign instr_o     = instr_q;
    assign npc_o       = npc_q;
    assign valid_o     = valid_q;
    assign fetch_stall = w_fetch_stall;
    assign halt_o      = halt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_latch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_decode_latch
//  Description : Randomized and directed self-checking bench for the IF/ID
//                latch against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_latch;

    localparam int WORD_W = 32;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic [WORD_W-1:0] npc_i;
    logic              stall;
    logic              flush;
    logic [WORD_W-1:0] instr_o;
    logic [WORD_W-1:0] npc_o;
    logic              valid_o;
    logic              fetch_stall;
    logic              halt_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: the word in decode, a queue holding at most one
    // parked word, and a halted flag.
    logic [WORD_W-1:0] m_instr;
    logic [WORD_W-1:0] m_npc;
    logic              m_valid;
    logic              m_halted;
    logic [63:0]       m_skid[$];

    logic [WORD_W-1:0] pc_ctr;

    fetch_decode_latch #(
        .WORD_W      (32),
        .NOP_INSTR   (32'h0),
        .HALT_OPCODE (6'h3F)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .imemload    (imemload),
        .npc_i       (npc_i),
        .stall       (stall),
        .flush       (flush),
        .instr_o     (instr_o),
        .npc_o       (npc_o),
        .valid_o     (valid_o),
        .fetch_stall (fetch_stall),
        .halt_o      (halt_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using the inputs present at the edge.
    task automatic model_edge();
        logic [63:0] w;
        if (!nRST) begin
            m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
            m_halted = 1'b0; m_skid.delete();
        end else if (m_halted) begin
            // frozen
        end else if (flush) begin
            m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
            m_skid.delete();
        end else if (m_valid && m_instr[31:26] == 6'h3F) begin
            m_halted = 1'b1;
            m_skid.delete();
        end else if (m_skid.size() != 0) begin
            if (!stall) begin
                w = m_skid.pop_front();
                m_instr = w[63:32]; m_npc = w[31:0]; m_valid = 1'b1;
            end
        end else if (stall) begin
            if (ihit) m_skid.push_back({imemload, npc_i});
        end else if (ihit) begin
            m_instr = imemload; m_npc = npc_i; m_valid = 1'b1;
        end else begin
            m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        logic exp_fs;
        exp_fs = m_halted || (m_skid.size() != 0);
        check({tag, ".instr"},  instr_o,              m_instr);
        check({tag, ".npc"},    npc_o,                m_npc);
        check({tag, ".valid"},  {31'b0, valid_o},     {31'b0, m_valid});
        check({tag, ".fstall"}, {31'b0, fetch_stall}, {31'b0, exp_fs});
        check({tag, ".halt"},   {31'b0, halt_o},      {31'b0, m_halted});
    endtask

    task automatic step(input string tag, input logic n, input logic ih, input logic [31:0] w,
                        input logic st, input logic fl);
        nRST = n; ihit = ih; imemload = w; npc_i = pc_ctr + 32'd4;
        stall = st; flush = fl;
        @(posedge CLK);
        model_edge();
        if (ih) pc_ctr = pc_ctr + 32'd4;
        #1;
        compare_all(tag);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    initial begin
        nRST = 1'b0; ihit = 1'b0; imemload = '0; npc_i = '0; stall = 1'b0; flush = 1'b0;
        pc_ctr = 32'h0000_1000;
        m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;

        // Reset
        step("rst0", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("rst.instr_zero", instr_o, 32'h0);

        // Streaming
        for (int i = 0; i < 4; i++) step("stream", 1'b1, 1'b1, 32'hA000_0000 + i, 1'b0, 1'b0);
        check("stream.A3", instr_o, 32'hA000_0003);
        step("idle", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Skid: B arrives during a stall, held while stall persists, then released
        step("skid.prev", 1'b1, 1'b1, 32'h1111_0000, 1'b0, 1'b0);
        step("skid.B",    1'b1, 1'b1, 32'hB000_0000, 1'b1, 1'b0);
        check("skid.hold", instr_o, 32'h1111_0000);
        step("skid.hold2", 1'b1, 1'b1, 32'hC000_0000, 1'b1, 1'b0);
        step("skid.rel",   1'b1, 1'b1, 32'hC000_0000, 1'b0, 1'b0);
        check("skid.outB", instr_o, 32'hB000_0000);
        step("skid.C",     1'b1, 1'b1, 32'hC000_0000, 1'b0, 1'b0);
        check("skid.outC", instr_o, 32'hC000_0000);

        // Flush and stall together with skid full and ihit high
        step("fl.fill", 1'b1, 1'b1, 32'hD000_0000, 1'b1, 1'b0);
        step("fl.hit",  1'b1, 1'b1, 32'hE000_0000, 1'b1, 1'b1);
        check("flush.valid", {31'b0, valid_o}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 70), rand_word(),
                 ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 5));
        end

        // Reset while the skid holds a word
        step("rs.a", 1'b1, 1'b1, 32'h2222_0000, 1'b0, 1'b0);
        step("rs.b", 1'b1, 1'b1, 32'h3333_0000, 1'b1, 1'b0);
        step("rs.rst", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("rs.fstall", {31'b0, fetch_stall}, 32'h0);
        step("rs.after", 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // HALT
        step("h.pre",  1'b1, 1'b1, 32'h4444_0000, 1'b0, 1'b0);
        step("h.word", 1'b1, 1'b1, 32'hFC00_0000, 1'b0, 1'b0);
        check("h.indecode", instr_o, 32'hFC00_0000);
        step("h.set",  1'b1, 1'b1, 32'h5555_0000, 1'b0, 1'b0);
        check("h.halt", {31'b0, halt_o}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            step("h.frozen", 1'b1, $urandom_range(0, 1), rand_word(),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end
        check("h.keep", instr_o, 32'hFC00_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
